// File: rtl/i2s_master_tx.sv
// I2S clock-master transmitter: divides clk down to bck/lrck and shifts one
// stereo sample pair per frame out MSB-first, one bck after each lrck edge.
module i2s_master_tx #(
  parameter int WORD_SIZE    = 32,
  parameter int SAMPLE_SIZE  = 24,
  parameter int CLKS_PER_BCK = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SAMPLE_SIZE-1:0] l_sample,
  input  logic [SAMPLE_SIZE-1:0] r_sample,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  output logic                   bck,
  output logic                   lrck,
  output logic                   dout,
  output logic                   frame_start,
  output logic                   underrun
);

  localparam int HALF  = CLKS_PER_BCK / 2;
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BIT_W = $clog2(2 * WORD_SIZE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * WORD_SIZE - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bck_q, bck_d;
  logic             lrck_q, lrck_d;
  logic             dout_q, dout_d;
  logic             hold_full_q, hold_full_d;
  logic             frame_start_q, frame_start_d;
  logic             underrun_q, underrun_d;
  logic signed [SAMPLE_SIZE-1:0] l_hold_q, l_hold_d, r_hold_q, r_hold_d;
  logic signed [SAMPLE_SIZE-1:0] l_shift_q, l_shift_d, r_shift_q, r_shift_d;

  logic wrap, fall_ev, load, xfer;
  logic lrck_nxt, ser_bit;
  logic [31:0] bit_ext, pos;
  logic signed [SAMPLE_SIZE-1:0] chan;

  assign wrap    = (div_cnt_q == DIV_LAST);
  assign fall_ev = wrap & bck_q;
  // A frame starts on the fall event that takes bit_cnt from its last value back to 0.
  assign load    = fall_ev & (bit_cnt_q == BIT_LAST);
  assign xfer    = sample_valid & ~hold_full_q;

  // Divider, bck toggle and bit position within the frame.
  always_comb begin
    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
    bck_d     = wrap ? ~bck_q : bck_q;
    bit_cnt_d = bit_cnt_q;
    if (fall_ev) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    end
  end

  // Serial bit for the upcoming slot position; slot bit 0 is the I2S one-bit delay.
  always_comb begin
    bit_ext  = 32'(bit_cnt_d);
    lrck_nxt = (bit_ext >= WORD_SIZE);
    pos      = lrck_nxt ? bit_ext - WORD_SIZE : bit_ext;
    chan     = lrck_nxt ? r_shift_q : l_shift_q;
    ser_bit  = 1'b0;
    for (int i = 0; i < SAMPLE_SIZE; i++) begin
      if (pos == 32'(SAMPLE_SIZE - i)) ser_bit = chan[i];
    end
    lrck_d = fall_ev ? lrck_nxt : lrck_q;
    dout_d = fall_ev ? ser_bit : dout_q;
  end

  // Holding register handshake and frame load into the shift registers.
  always_comb begin
    hold_full_d = hold_full_q;
    if (load) hold_full_d = 1'b0;
    if (xfer) hold_full_d = 1'b1;
    l_hold_d  = xfer ? l_sample : l_hold_q;
    r_hold_d  = xfer ? r_sample : r_hold_q;
    l_shift_d = l_shift_q;
    r_shift_d = r_shift_q;
    if (load) begin
      l_shift_d = hold_full_q ? l_hold_q : '0;
      r_shift_d = hold_full_q ? r_hold_q : '0;
    end
    frame_start_d = load;
    underrun_d    = load & ~hold_full_q;
  end

  // Control, timing and shift state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      bit_cnt_q     <= BIT_LAST;
      bck_q         <= 1'b0;
      lrck_q        <= 1'b0;
      dout_q        <= 1'b0;
      hold_full_q   <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      l_shift_q     <= '0;
      r_shift_q     <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      bck_q         <= bck_d;
      lrck_q        <= lrck_d;
      dout_q        <= dout_d;
      hold_full_q   <= hold_full_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      l_shift_q     <= l_shift_d;
      r_shift_q     <= r_shift_d;
    end
  end

  // Holding data is qualified by hold_full, so it needs no reset.
  always_ff @(posedge clk) begin
    l_hold_q <= l_hold_d;
    r_hold_q <= r_hold_d;
  end

  assign sample_ready = ~hold_full_q;
  assign bck          = bck_q;
  assign lrck         = lrck_q;
  assign dout         = dout_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;

endmodule

// File: doc/i2s_master_tx.md
# i2s_master_tx

- Clock-master I2S transmitter for the DAC path.
- Divides the system clock to generate bck and lrck.
- Accepts one stereo 24-bit sample pair per frame through a valid/ready handshake and serializes it MSB-first in 32-bit slots.
- Sits between the processing/TX-buffer logic and the o_dac_bck / o_dac_lrck / o_dac_adata pins, replacing the slave-mode transmitter when the FPGA is the audio clock master.

## Interface
- WORD_SIZE, 32: bits per channel slot.
- SAMPLE_SIZE, 24: sample width. Must be ≤ WORD_SIZE-1.
- CLKS_PER_BCK, 8: clk cycles per bck period. Must be even and ≥2.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- l_sample  input  SAMPLE_SIZE  left sample, two's complement.
- r_sample  input  SAMPLE_SIZE  right sample, two's complement.
- sample_valid  input  1  l_sample/r_sample valid.
- sample_ready  output  1  holding register empty; a transfer occurs when valid && ready at a clk edge.
- bck  output  1  bit clock.
- lrck  output  1  word clock; 0 = left slot, 1 = right slot.
- dout  output  1  serial data.
- frame_start  output  1  one-clk pulse when a new frame's samples are loaded.
- underrun  output  1  one-clk pulse when a frame loads with an empty holding register.

## Operation
- **Divider:** div_cnt counts 0..CLKS_PER_BCK/2-1 and wraps.
  - On wrap, bck toggles.
  - A wrap where bck goes 1→0 is a fall event; 0→1 is a rise event.
- **Bit counter:** bit_cnt runs 0..2*WORD_SIZE-1. It increments on each fall event and wraps to 0.
- **Outputs:** bck, lrck and dout are registers. All three update on the same clk edge as the fall event.
  - New lrck = (new bit_cnt ≥ WORD_SIZE).
  - Slot position p = new bit_cnt mod WORD_SIZE.
  - Standard I2S one-bit delay for dout:
    - p = 0: drive 0.
    - p = 1..SAMPLE_SIZE: drive shift bit SAMPLE_SIZE-p of the current channel.
    - p > SAMPLE_SIZE: drive 0.
- **Holding register:** l_hold/r_hold plus hold_full; sample_ready = !hold_full.
  - A transfer captures both samples and sets hold_full.
- **Frame load:** occurs on the fall event where bit_cnt wraps to 0.
  - If hold_full: copy hold → l_shift/r_shift and clear hold_full.
  - Else: load zeros into l_shift/r_shift and pulse underrun.
  - frame_start pulses on every frame load.
- **Simultaneous transfer and frame load, hold empty:** the load sees empty, so zeros go out and underrun pulses. The new pair lands in hold and is used at the next frame.
- **Simultaneous transfer and frame load, hold full:** cannot occur, because ready is 0 while hold is full.
- **Reset values:**
  - Outputs: bck=0, lrck=0, dout=0, sample_ready=1, frame_start=0, underrun=0.
  - Internal: div_cnt=0, bit_cnt=2*WORD_SIZE-1, hold_full=0, shift registers=0.
- **Reset mid-frame:** all state returns to reset values immediately and asynchronously. The partial frame is abandoned, with no completion.
- **After reset release:** the first fall event wraps bit_cnt to 0 and performs a frame load. That load underruns unless a pair was transferred first.
- Sample arithmetic: samples are passed through bit-exact; no truncation or rounding.

## Timing
- bck period: CLKS_PER_BCK clk cycles, 50% duty.
- Frame: 2*WORD_SIZE*CLKS_PER_BCK clk cycles (512 at defaults).
- After reset release:
  - First rise event at clk edge CLKS_PER_BCK/2.
  - First fall event at edge CLKS_PER_BCK.
- dout and lrck change only at fall events. The DAC samples on bck rise, CLKS_PER_BCK/2 cycles later.
- Latency from frame load to left MSB on dout: one bck period (CLKS_PER_BCK cycles).
- Latency from frame load to right MSB: WORD_SIZE+1 bck periods.
- sample_ready:
  - Falls the cycle after a transfer.
  - Rises the cycle after the frame load that consumes the hold register.
  - Under continuous valid, exactly one transfer occurs per frame.
- frame_start and underrun are asserted for exactly one clk cycle, coincident with the lrck 1→0 output update.

## Test plan
- **Reset:**
  - Stimulus: assert rst mid-frame (bit_cnt ≈ 40).
  - Required: all outputs take reset values within the same cycle.
  - Required after release: first bck rise at edge 4, first fall at edge 8, frame_start at edge 8.
- **Bit pattern:**
  - Stimulus: transfer l=0x800001, r=0x7FFFFE before the first frame.
  - Required left slot dout after lrck falls: 0, 1, 0×22, 1, 0×7.
  - Required right slot after lrck rises: 0, 0, 1×22, 0, 0×7.
- **Underrun:**
  - Stimulus: no transfers.
  - Required: underrun and frame_start pulse once every 512 cycles; dout stays 0.
- **Streaming:**
  - Stimulus: sample_valid held high with an incrementing counter.
  - Required: one transfer per frame; ready low from transfer until frame load; consecutive frames carry consecutive values; no underrun after the first frame.
- **Collision:**
  - Stimulus: assert valid with hold empty in exactly the frame-load cycle.
  - Required: underrun pulses, the current frame is zero, and that pair appears in the next frame.
- **Parameters:**
  - Stimulus: CLKS_PER_BCK=2, WORD_SIZE=32.
  - Required: bck toggles every clk cycle, frame length is 128 cycles, and the bit pattern matches the bit-pattern test.
